// File: rtl/reg_wb_scheduler.sv
// Register writeback scheduler: a busy scoreboard that stalls issue on
// RAW/WAW hazards, plus a round-robin arbiter for the single register-file
// write port shared by the ALU and LSU writeback paths.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   issue_*                      decode-stage instruction and hazard stall
//   alu_wb_*, lsu_wb_*           writeback requesters (valid/ready handshake)
//   rf_addr_rd, rf_write_enable,
//   rf_data_rd                   register-file write port
//   busy_mask                    scoreboard state, bit i = write to xi in flight
//   wb_error                     sticky: writeback hit a non-busy nonzero register
module reg_wb_scheduler #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH     = 32,
    localparam int unsigned NUM_REGS      = 2 ** REG_ADDR_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic                      issue_writes_rd,
    output logic                      issue_stall,
    input  logic                      alu_wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alu_wb_rd,
    input  logic [DATA_WIDTH-1:0]     alu_wb_data,
    output logic                      alu_wb_ready,
    input  logic                      lsu_wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] lsu_wb_rd,
    input  logic [DATA_WIDTH-1:0]     lsu_wb_data,
    output logic                      lsu_wb_ready,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr_rd,
    output logic                      rf_write_enable,
    output logic [DATA_WIDTH-1:0]     rf_data_rd,
    output logic [NUM_REGS-1:0]       busy_mask,
    output logic                      wb_error
);

    localparam logic [0:0] GRANT_ALU = 1'b0;
    localparam logic [0:0] GRANT_LSU = 1'b1;

    logic [NUM_REGS-1:0]       busy_q;
    logic [NUM_REGS-1:0]       busy_d;
    logic [0:0]                last_grant_q;
    logic [0:0]                last_grant_d;
    logic                      wb_error_q;
    logic                      wb_error_d;

    logic                      grant_alu;
    logic                      grant_lsu;
    logic                      wb_fire;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0]     wb_data;
    logic                      issue_set;
    logic                      wb_clear;

    // Hazard check uses registered busy only; a clear becomes visible next cycle.
    assign issue_stall = issue_valid &
                         (busy_q[issue_rs1] | busy_q[issue_rs2] |
                          (issue_writes_rd & busy_q[issue_rd]));

    assign issue_set = issue_valid & ~issue_stall & issue_writes_rd &
                       (issue_rd != '0);

    // Round-robin: on a tie the requester that did not win last time goes.
    assign grant_alu = alu_wb_valid & (~lsu_wb_valid | (last_grant_q == GRANT_LSU));
    assign grant_lsu = lsu_wb_valid & ~grant_alu;
    assign wb_fire   = grant_alu | grant_lsu;

    // Write-port mux; all-zero when idle.
    always_comb begin
        wb_rd   = '0;
        wb_data = '0;
        if (grant_alu) begin
            wb_rd   = alu_wb_rd;
            wb_data = alu_wb_data;
        end else if (grant_lsu) begin
            wb_rd   = lsu_wb_rd;
            wb_data = lsu_wb_data;
        end
    end

    assign wb_clear = wb_fire & (wb_rd != '0);

    // Next scoreboard, error and arbitration state; clear wins over set.
    always_comb begin
        busy_d       = busy_q;
        last_grant_d = last_grant_q;
        wb_error_d   = wb_error_q;
        if (issue_set) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (wb_clear) begin
            busy_d[wb_rd] = 1'b0;
            if (!busy_q[wb_rd]) begin
                wb_error_d = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
        if (grant_alu) begin
            last_grant_d = GRANT_ALU;
        end else if (grant_lsu) begin
            last_grant_d = GRANT_LSU;
        end
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q       <= '0;
            last_grant_q <= GRANT_LSU;
            wb_error_q   <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            wb_error_q   <= wb_error_d;
        end
    end

    assign alu_wb_ready    = grant_alu;
    assign lsu_wb_ready    = grant_lsu;
    assign rf_write_enable = wb_fire;
    assign rf_addr_rd      = wb_rd;
    assign rf_data_rd      = wb_data;
    assign busy_mask       = busy_q;
    assign wb_error        = wb_error_q;

endmodule

// File: doc/reg_wb_scheduler.md
Name: reg_wb_scheduler

Overview:
Sits between the issue stage, the execution units and the single register-file write port.
- Tracks a per-register busy scoreboard and stalls issue on RAW/WAW hazards against in-flight writes.
- Arbitrates the one write port between the ALU and LSU writeback requesters with round-robin priority and valid/ready handshakes.
- Drives the register file's write address, write-enable and write-data inputs directly.

Parameters:
- REG_ADDR_WIDTH, 5, register index width; NUM_REGS = 2**REG_ADDR_WIDTH.
- DATA_WIDTH, 32, writeback data width (arch_reg).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction.
- issue_rs1  in  REG_ADDR_WIDTH  source 1 index.
- issue_rs2  in  REG_ADDR_WIDTH  source 2 index.
- issue_rd  in  REG_ADDR_WIDTH  destination index.
- issue_writes_rd  in  1  instruction writes rd.
- issue_stall  out  1  hazard; issue must hold.
- alu_wb_valid  in  1  ALU result pending.
- alu_wb_rd  in  REG_ADDR_WIDTH  ALU destination.
- alu_wb_data  in  DATA_WIDTH  ALU result.
- alu_wb_ready  out  1  ALU result accepted this cycle.
- lsu_wb_valid  in  1  load result pending.
- lsu_wb_rd  in  REG_ADDR_WIDTH  load destination.
- lsu_wb_data  in  DATA_WIDTH  load data.
- lsu_wb_ready  out  1  load result accepted this cycle.
- rf_addr_rd  out  REG_ADDR_WIDTH  to register-file write address.
- rf_write_enable  out  1  to register-file write enable.
- rf_data_rd  out  DATA_WIDTH  to register-file write data.
- busy_mask  out  NUM_REGS  scoreboard state; bit i = write to xi in flight.
- wb_error  out  1  sticky; writeback to a non-busy nonzero register.

Behaviour:
Reset (async, immediate):
- busy_mask = 0, wb_error = 0, last_grant = LSU, so the ALU wins the first tie.
- All combinational outputs derive from this state; with no valids, ready and rf_write_enable are 0.

Scoreboard:
- Bit 0 is never set and always reads 0.
- issue_stall (combinational, from registered busy only, no same-cycle bypass) = issue_valid & (busy[rs1] | busy[rs2] | (issue_writes_rd & busy[rd])).
- Issue is accepted when issue_valid & !issue_stall.
- On an accepted issue with issue_writes_rd and rd != 0, busy[rd] is set at the next edge.
- A granted writeback clears busy[wb_rd] at the next edge.
- Set and clear of the same bit in one cycle cannot occur: a set requires the bit clear, a clear requires it set. The clear applies in that case if it ever occurs.
- A register cleared in cycle N unstalls a dependent issue in cycle N+1, giving 1-cycle hazard latency.

Arbitration (combinational grant, single port):
- Only one valid: that requester is granted.
- Both valid: the requester not equal to last_grant is granted. last_grant updates on every grant.
- Granted: its ready = 1, rf_write_enable = 1, rf_addr_rd/rf_data_rd = its rd/data. The transfer completes in that same cycle.
- Ungranted: ready = 0; the requester must hold valid, rd and data stable until ready.
- No valid: rf_write_enable = 0, rf_addr_rd = 0, rf_data_rd = 0.
- Writeback with rd = 0: granted and rf_write_enable asserted (the register file discards x0). There is no busy change and no error.
- Writeback with rd != 0 and busy[rd] = 0: still performed; wb_error is set and holds until reset.
- Both requesters targeting the same rd: this is legal only if software ordering allows it. It is served in round-robin order; the first grant clears busy, and the second sets wb_error.

Test Plan:
- Reset mid-operation with busy_mask = 0x0000_0024 and both valids high -> busy_mask = 0, wb_error = 0, and the next tie grants ALU.
- Issue rd = x5 (writes) -> busy_mask = 0x20. Issue rs1 = x5 -> issue_stall = 1 until an ALU writeback to x5 is granted; stall drops the following cycle.
- ALU rd = x3, data 0xDEAD_BEEF, and LSU rd = x4, data 0x1234_5678, valid together for 2 cycles, both busy -> cycle 0 ALU write (x3, 0xDEADBEEF), cycle 1 LSU write (x4, 0x12345678), busy bits 3 and 4 cleared.
- WAW: x7 busy, issue rd = x7, rs1 = rs2 = x0 -> stall. Grant x7 writeback -> the re-issue is accepted the next cycle and busy[7] is set again.
- Issue rd = x0 with writes_rd = 1 -> no stall, busy_mask unchanged. LSU writeback rd = x0 -> rf_write_enable = 1, wb_error stays 0.
- LSU writeback to x9 with busy[9] = 0 -> the write is performed and wb_error = 1, staying 1 after 10 idle cycles.
